// File: rtl/fp13_mul_arbiter_pkg.sv
// Shared definitions for the fp13 multiplier arbiter: float word layout,
// requester IDs and controller state encoding.
package fp13_mul_arbiter_pkg;

  localparam int unsigned NB_FLOAT = 13;

  localparam int unsigned SIGN_BIT = 12;
  localparam int unsigned EXP_MSB  = 11;
  localparam int unsigned EXP_LSB  = 8;
  localparam int unsigned MAN_MSB  = 7;
  localparam int unsigned MAN_LSB  = 0;
  localparam int unsigned EXP_BIAS = 7;
  localparam int unsigned EXP_MAX  = 15;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage : fp13_mul_arbiter_pkg

// File: rtl/fp13_mul_arbiter_fmul.sv
// Combinational 13-bit float multiplier (1/4/8, bias 7). Zero exponent is
// treated as zero, mantissa product is truncated, overflow saturates.
module fp13_mul_arbiter_fmul
  import fp13_mul_arbiter_pkg::*;
(
  input  logic [NB_FLOAT-1:0] op1_i,
  input  logic [NB_FLOAT-1:0] op2_i,
  output logic [NB_FLOAT-1:0] prod_o
);

  logic        sign;
  logic [3:0]  exp_a, exp_b, exp_r;
  logic [8:0]  man_a, man_b;
  logic [17:0] man_prod;
  logic        norm;
  logic [7:0]  man_r;
  logic [5:0]  exp_sum;

  always_comb begin
    sign     = op1_i[SIGN_BIT] ^ op2_i[SIGN_BIT];
    exp_a    = op1_i[EXP_MSB:EXP_LSB];
    exp_b    = op2_i[EXP_MSB:EXP_LSB];
    man_a    = {1'b1, op1_i[MAN_MSB:MAN_LSB]};
    man_b    = {1'b1, op2_i[MAN_MSB:MAN_LSB]};
    man_prod = {9'b0, man_a} * {9'b0, man_b};
    // Product of two 1.x values lies in [1,4); bit 17 set means [2,4).
    norm     = man_prod[17];
    man_r    = norm ? man_prod[16:9] : man_prod[15:8];
    exp_sum  = {2'b00, exp_a} + {2'b00, exp_b} + {5'b0, norm};
    exp_r    = 4'(exp_sum - 6'(EXP_BIAS));

    if ((exp_a == '0) || (exp_b == '0) || (exp_sum <= 6'(EXP_BIAS))) begin
      prod_o = {sign, 12'b0};
    end else if (exp_sum > 6'(EXP_BIAS + EXP_MAX)) begin
      prod_o = {sign, 12'hFFF};
    end else begin
      prod_o = {sign, exp_r, man_r};
    end
  end

endmodule : fp13_mul_arbiter_fmul

// File: rtl/fp13_mul_arbiter.sv
// Round-robin controller sharing one fp13 multiplier between requesters A/B,
// with registered operands and a held result until the consumer accepts it.
module fp13_mul_arbiter
  import fp13_mul_arbiter_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid_a,
  input  logic [NB_FLOAT-1:0] i_op1_a,
  input  logic [NB_FLOAT-1:0] i_op2_a,
  output logic                o_ready_a,
  input  logic                i_valid_b,
  input  logic [NB_FLOAT-1:0] i_op1_b,
  input  logic [NB_FLOAT-1:0] i_op2_b,
  output logic                o_ready_b,
  output logic [NB_FLOAT-1:0] o_result,
  output logic                o_result_id,
  output logic                o_result_valid,
  input  logic                i_result_ready,
  output logic                o_busy
);

  state_t              state_q, state_d;
  logic [NB_FLOAT-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [NB_FLOAT-1:0] result_q, result_d;
  logic                id_q, id_d;
  logic                rr_q, rr_d;
  logic                grant_a, grant_b;
  logic                xfer_a, xfer_b;
  logic [NB_FLOAT-1:0] mul_prod;

  fp13_mul_arbiter_fmul u_fmul (
    .op1_i  (op1_q),
    .op2_i  (op2_q),
    .prod_o (mul_prod)
  );

  // rr_q names the requester that wins when both are valid.
  always_comb begin
    grant_a = i_valid_a & (~i_valid_b | (rr_q == ID_A));
    grant_b = i_valid_b & (~i_valid_a | (rr_q == ID_B));
    xfer_a  = i_valid_a & o_ready_a;
    xfer_b  = i_valid_b & o_ready_b;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (xfer_a || xfer_b) state_d = S_CALC;
      S_CALC:  state_d = S_DONE;
      S_DONE:  if (i_result_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_ready_a      = (state_q == S_IDLE) & grant_a;
    o_ready_b      = (state_q == S_IDLE) & grant_b;
    o_result_valid = (state_q == S_DONE);
    o_busy         = (state_q != S_IDLE);
    o_result       = result_q;
    o_result_id    = id_q;
  end

  always_comb begin
    op1_d    = op1_q;
    op2_d    = op2_q;
    id_d     = id_q;
    rr_d     = rr_q;
    result_d = result_q;
    if (xfer_a) begin
      op1_d = i_op1_a;
      op2_d = i_op2_a;
      id_d  = ID_A;
      rr_d  = ID_B;
    end else if (xfer_b) begin
      op1_d = i_op1_b;
      op2_d = i_op2_b;
      id_d  = ID_B;
      rr_d  = ID_A;
    end
    if (state_q == S_CALC) begin
      result_d = mul_prod;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op1_q    <= '0;
      op2_q    <= '0;
      id_q     <= ID_A;
      rr_q     <= ID_A;
      result_q <= '0;
    end else begin
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      id_q     <= id_d;
      rr_q     <= rr_d;
      result_q <= result_d;
    end
  end

endmodule : fp13_mul_arbiter
